// File: rtl/delay_line_pkg.sv
// Shared definitions for the delay line: FSM state encoding and DEPTH legality check.
package delay_line_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   function automatic bit depth_ok(input int depth);
      return (depth >= 4) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port block RAM: one write port, one registered read port, read-first.
module dual_port_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rd_en) rd_data <= mem[raddr];
   end

endmodule

// File: rtl/delay_line_buffer.sv
// Programmable sample delay line over a circular block-RAM buffer with valid/ready on both sides.
// Define DELAY_LINE_CLEAR_EN to zero the buffer with a DEPTH-cycle sweep after every reset.
module delay_line_buffer
   import delay_line_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] delay,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   if (!depth_ok(DEPTH)) begin : g_depth_chk
      $error("delay_line_buffer: DEPTH must be a power of two >= 4");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic                  out_valid_q, out_valid_d;
   logic                  byp_q, byp_d;
   logic [WIDTH-1:0]      byp_data_q, byp_data_d;
   logic                  run;
   logic                  accept;
   logic                  sweep_we;
   logic [ADDR_WIDTH-1:0] sweep_addr;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [WIDTH-1:0]      ram_wdata;
   logic [WIDTH-1:0]      ram_rdata;

`ifdef DELAY_LINE_CLEAR_EN
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      if (state_q == CLEAR) begin
         clr_addr_d = clr_addr_q + 1'b1;
         if (clr_addr_q == LAST_ADDR) state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign run        = (state_q == RUN);
   assign busy       = (state_q == CLEAR);
   assign sweep_we   = (state_q == CLEAR);
   assign sweep_addr = clr_addr_q;
`else
   assign run        = 1'b1;
   assign busy       = 1'b0;
   assign sweep_we   = 1'b0;
   assign sweep_addr = '0;
`endif

   assign in_ready = run && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      out_valid_d = out_valid_q;
      byp_d       = byp_q;
      byp_data_d  = byp_data_q;
      if (accept) begin
         wr_ptr_d    = wr_ptr_q + 1'b1;
         out_valid_d = 1'b1;
         byp_d       = (delay == '0);
         byp_data_d  = in_data;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Bypass path resets selected with zero data so out_data reads 0 out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         byp_q       <= 1'b1;
         byp_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         out_valid_q <= out_valid_d;
         byp_q       <= byp_d;
         byp_data_q  <= byp_data_d;
      end
   end

   assign ram_we    = !rst && (sweep_we || accept);
   assign ram_waddr = sweep_we ? sweep_addr : wr_ptr_q;
   assign ram_wdata = sweep_we ? '0 : in_data;

   dual_port_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .rd_en   (accept),
      .raddr   (wr_ptr_q - delay),
      .rd_data (ram_rdata)
   );

   assign out_valid = out_valid_q;
   assign out_data  = byp_q ? byp_data_q : ram_rdata;

endmodule

// File: tb/tb_delay_line_buffer.sv
// Randomized self-checking bench for delay_line_buffer against a sample-history reference model.
module tb_delay_line_buffer;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);
`ifdef DELAY_LINE_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [AW-1:0]    delay;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   always #5 clk = ~clk;

   delay_line_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .delay     (delay),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   int tests = 0;
   int fails = 0;

   // Reference: every accepted sample since reset, in order; output n is sample n-delay.
   logic [WIDTH-1:0] hist[$];
   logic             exp_valid;
   logic [WIDTH-1:0] exp_data;
   bit               exp_known;
   int               clr_left;
   bit               acc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock: inputs are already set; predict, then check outputs after the edge.
   task automatic step(output bit accepted);
      bit rdy;
      int idx;
      @(negedge clk);
      rdy = (clr_left == 0) && (!exp_valid || out_ready);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("busy", 32'(busy), 32'(clr_left != 0));
      accepted = in_valid && rdy;
      if (accepted) begin
         hist.push_back(in_data);
         idx = hist.size() - 1 - int'(delay);
         if (idx >= 0) begin
            exp_data  = hist[idx];
            exp_known = 1'b1;
         end else begin
            exp_data  = '0;
            exp_known = CLR;
         end
         exp_valid = 1'b1;
      end else if (out_ready) begin
         exp_valid = 1'b0;
      end
      if (clr_left > 0) clr_left--;
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid && exp_known) chk("out_data", 32'(out_data), 32'(exp_data));
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      hist.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_known = 1'b1;
      clr_left  = CLR ? DEPTH : 0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'(CLR));
   endtask

   task automatic wait_clear();
      in_valid = 1'b0;
      while (clr_left > 0) step(acc);
   endtask

   initial begin
      int cnt;
      rst       = 1'b1;
      delay     = '0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_known = 1'b1;
      clr_left  = 0;
      do_reset();

      // Stream 1,2,3,... with delay 3 held pending through the clear window.
      delay    = 3;
      cnt      = 1;
      in_data  = 8'(cnt);
      in_valid = 1'b1;
      for (int i = 0; i < DEPTH + 12; i++) begin
         step(acc);
         if (acc) begin
            cnt++;
            in_data = 8'(cnt);
         end
      end
      in_valid = 1'b0;
      step(acc);

      // Zero delay takes the bypass path.
      delay    = 0;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      step(acc);
      in_data = 8'h5A;
      step(acc);
      in_valid = 1'b0;
      step(acc);

      // Maximum delay across several pointer wraps.
      do_reset();
      wait_clear();
      delay    = 15;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_data = 8'(i);
         step(acc);
      end

      // Backpressure: outputs must hold while out_ready is low.
      delay     = 2;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_data = 8'($urandom);
         step(acc);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 8'(200 + i);
         step(acc);
      end

      // Delay change mid-stream.
      do_reset();
      wait_clear();
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         delay   = (i < 10) ? AW'(4) : AW'(1);
         in_data = 8'(100 + i);
         step(acc);
      end

      // Reset while an output is stalled, then verify no stale history leaks out.
      delay = 5;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(50 + i);
         step(acc);
      end
      out_ready = 1'b0;
      in_data   = 8'h77;
      step(acc);
      do_reset();
      out_ready = 1'b1;
      wait_clear();
      in_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_data = 8'(30 + i);
         step(acc);
      end

      // Random traffic, delays and backpressure.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         if (($urandom % 16) == 0) delay = AW'($urandom);
         in_data = 8'($urandom);
         step(acc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/delay_line_buffer.md
Name: delay_line_buffer

Overview:
- Programmable-length sample delay line for the delay-line datapath.
- Stores a stream of WIDTH-bit samples in a circular buffer built on block RAM.
- Each accepted input sample produces one output sample equal to the input accepted `delay` samples earlier.
- Valid/ready handshakes on both sides; next-generation replacement for bare RAM plus external pointer logic.

Parameters:
- WIDTH, 8, sample width in bits.
- DEPTH, 16, buffer entries; must be a power of two, at least 4. Maximum delay is DEPTH-1.
- ADDR_WIDTH, $clog2(DEPTH), localparam; pointer and delay width.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- delay  input  ADDR_WIDTH  delay in samples, 0..DEPTH-1; sampled on every accepted input.
- in_data  input  WIDTH  input sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a sample.
- out_data  output  WIDTH  delayed sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, wr_ptr=0.
  - With clear enabled: busy=1, in_ready=0.
  - Without clear: busy=0, in_ready=1.
- State machine states: CLEAR, RUN.
- CLEAR:
  - Address counter clr_addr runs 0..DEPTH-1, writing 0 to one entry per cycle.
  - Outputs in_ready=0, busy=1.
  - After clr_addr==DEPTH-1 is written, the next state is RUN. CLEAR lasts exactly DEPTH cycles.
- RUN:
  - in_ready = !out_valid || out_ready.
  - Accept occurs when in_valid && in_ready.
- On accept:
  - Write in_data to mem[wr_ptr].
  - Read mem[(wr_ptr - delay) mod DEPTH], registered.
  - wr_ptr increments, wrapping DEPTH-1 -> 0.
  - out_valid=1 next cycle.
- Latency: out_data and out_valid appear 1 cycle after accept.
- Stall: while out_valid && !out_ready, out_data holds stable, in_ready=0, and the RAM read enable is low.
- Output cleared: if out_ready is high with no accept in the same cycle, out_valid falls to 0.
- Accept and drain in the same cycle are allowed: out_valid stays 1 and out_data updates.
- delay==0: RAM read is bypassed; out_data is the registered in_data, so same-address read-during-write is never relied upon.
- Delay change mid-stream: takes effect on the next accepted sample. There is no flush; the output jumps to the new tap.
- History older than the clear sweep reads as 0, so the first `delay` outputs after CLEAR are 0.
- Reset mid-operation:
  - An in-flight output is dropped and out_valid goes to 0 in the next cycle.
  - wr_ptr returns to 0 and the clear sweep restarts from address 0.
- Address arithmetic is modulo DEPTH in ADDR_WIDTH bits; wrap is natural, with no comparison logic.

Optional Feature:
- Macro: DELAY_LINE_CLEAR_EN.
- Defined: CLEAR state present; reset triggers the DEPTH-cycle zero sweep; busy is meaningful.
- Undefined:
  - FSM reduces to RUN only; busy is tied 0; in_ready is high from the first cycle after reset.
  - Buffer contents after reset are whatever RAM holds: zeros after configuration, stale data after a reset mid-run.

Decomposition:
- Shared package delay_line_pkg: state encoding (CLEAR, RUN) and a DEPTH power-of-two check constant/function.
- One sub-module, natural and required: the existing dual_port_ram (WIDTH, DEPTH) as storage.
  - Write port is muxed between the clear sweep and the input stream.
  - Read port is driven by the tap pointer with rd_en = accept.
- Pointer/FSM/handshake logic lives in delay_line_buffer.

Test Plan:
- Reset with clear, WIDTH=8, DEPTH=16:
  - busy=1 and in_ready=0 for exactly 16 cycles, then in_ready=1.
  - Feed 1,2,3,... with delay=3 -> outputs 0,0,0,1,2,3,...
- delay=0, stream 0xA5, 0x5A back-to-back with out_ready=1 -> outputs 0xA5, 0x5A, each one cycle after accept.
- delay=15, stream 40 samples, values = index -> output n = n-15 for n>=15, else 0; verifies wrap of wr_ptr.
- Backpressure: delay=2, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable, no sample lost or duplicated once out_ready=1.
- Delay change: run delay=4, switch to delay=1 at sample 10 -> output for sample 10 is sample 9.
- Reset mid-run:
  - Assert rst while out_valid=1 -> out_valid=0 in the next cycle and the sweep restarts.
  - After the sweep, outputs are 0 for the first `delay` samples, with no stale data.
